fetch_aligner: RTL and testbench
================================

# fetch_aligner

Sits between the instruction memory port and the compressed-instruction expander. It fetches aligned 32-bit words and keeps a four-halfword queue. From that queue it emits one instruction per cycle, either 16-bit (RVC) or 32-bit, together with its PC. 32-bit instructions that straddle a word boundary are reassembled. On a redirect (branch/rollback) it flushes its state and discards any in-flight fetch response.

## Interface
Parameters:
- ADDR_W, 32, PC/address width
- RESET_PC, 32'h0, PC of the first instruction after reset; must be halfword aligned

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; when low, all state holds
- redirect_valid  in  1  flush and restart at redirect_pc
- redirect_pc  in  ADDR_W  new PC; bit 0 is ignored
- mem_req_valid  out  1  word fetch request
- mem_req_addr  out  ADDR_W  fetch address; bits [1:0] are always 0
- mem_req_ready  in  1  request accepted this cycle
- mem_resp_valid  in  1  fetch data valid; at most one response per accepted request, in order
- mem_resp_data  in  32  fetched word, little-endian halfwords
- stall  in  1  downstream cannot accept a new instruction
- out_valid  out  1  out_inst/out_pc valid
- out_inst  out  32  instruction; 16-bit ones are zero-extended in [15:0]
- out_pc  out  ADDR_W  PC of out_inst
- out_is_c  out  1  out_inst is 16-bit

## Operation
- State:
  - queue hq[0..3] of halfwords, with count 0..4
  - head_pc
  - fetch_addr (word aligned)
  - skip_low flag
  - FSM {IDLE, REQ, WAIT, DROP}
- mem_req_valid = (state==REQ); mem_req_addr = fetch_addr. A request is committed only in a cycle with valid && ready. At most one request is outstanding.
- Response push, in WAIT with mem_resp_valid:
  - If skip_low: push only data[31:16] (+1 halfword) and clear skip_low.
  - Otherwise push data[15:0] then data[31:16] (+2 halfwords).
  - Then fetch_addr += 4.
- Emission, evaluated when out register is free (!out_valid || !stall):
  - If count>=1 and hq[0][1:0]!=2'b11: emit {16'b0,hq[0]}, out_is_c=1, pop 1, head_pc+=2.
  - Else if hq[0][1:0]==2'b11 and count>=2: emit {hq[1],hq[0]}, out_is_c=0, pop 2, head_pc+=4.
  - Else out_valid<=0.
  - count_next = count - pop + push; push and pop in the same cycle is legal.
- FSM transitions (no redirect):
  - IDLE->REQ when count_next<=2.
  - REQ->WAIT on mem_req_ready.
  - WAIT->(count_next<=2 ? REQ : IDLE) on mem_resp_valid.
  - DROP->REQ on mem_resp_valid; the response is discarded.
- Redirect (highest priority):
  - count<=0, out_valid<=0, head_pc<=redirect_pc&~1, fetch_addr<=redirect_pc&~3, skip_low<=redirect_pc[1].
  - Next state:
    - DROP if a request is outstanding after this cycle (state WAIT without mem_resp_valid, or REQ with mem_req_ready).
    - Otherwise REQ.
  - Any response or emission in that cycle is discarded.
- Wrap-around: fetch_addr and head_pc wrap modulo 2^ADDR_W.
- The memory side never asserts mem_resp_valid while rdy is low.

## Timing
- Reset values:
  - out_valid=0, out_inst=0, out_pc=0, out_is_c=0, count=0
  - head_pc=RESET_PC, fetch_addr=RESET_PC&~3, skip_low=RESET_PC[1]
  - state=REQ, so mem_req_valid=1 the first cycle after reset.
- Reset mid-operation overrides redirect and everything else. Any in-flight response afterwards is the memory side's responsibility to squash.
- All outputs are registered except mem_req_valid/mem_req_addr, which are direct decodes of registers.
- Latency:
  - Accepted request at cycle A with response at cycle R: the first instruction from that word is on out_valid at R+1.
  - Redirect at T gives mem_req_valid at T+1 (or after the DROP response).
- Outputs hold stable while out_valid && stall.
- Throughput: one instruction per cycle when the queue holds the next instruction.

## Test plan
- Reset with RESET_PC=0, memory has 0x00A00093 at 0x0 and ready=1, latency 1:
  - mem_req addr 0x0 at cycle 1.
  - out_inst=0x00A00093, out_pc=0x0, out_is_c=0.
- Word 0x4 = 0x45050001: two consecutive outputs 0x0001 @0x4 then 0x4505 @0x6, both out_is_c=1.
- Straddling instruction, word 0x8 = 0x00934581 and word 0xC = 0x000100A0:
  - 0x4581 @0x8 (c), then 0x00A00093 @0xA (32-bit), then 0x0001 @0xE.
- Redirect to 0x102 while WAIT:
  - The pending response is dropped (no output).
  - Next request addr 0x100; only its upper halfword is used; first out_pc=0x102.
- stall held high 5 cycles with the queue full: out_* are stable, no request issues (state IDLE, count=4), and no halfword is lost after release.
- Redirect and mem_resp_valid in the same cycle in WAIT: the response is discarded, state goes to REQ, and out_valid=0 the next cycle.

Source files
------------

// File: rtl/fetch_aligner.sv
// Fetch aligner: word fetches into a four-halfword queue, emitting one
// RVC or 32-bit instruction per cycle with its PC.
module fetch_aligner #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_data,
    input  logic              stall,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              out_is_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    localparam logic [ADDR_W-1:0] HW_MASK = ~ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WD_MASK = ~ADDR_W'(3);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_hq [4];
    logic [2:0]        r_count;
    logic [ADDR_W-1:0] r_head_pc;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic              r_skip_low;
    logic              r_out_valid;
    logic [31:0]       r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;
    logic              r_out_is_c;

    logic              w_push_en;
    logic [2:0]        w_push_n;
    logic [15:0]       w_ph0;
    logic [15:0]       w_ph1;
    logic [15:0]       w_cq [8];
    logic [15:0]       w_nq [4];
    logic [2:0]        w_cnt;
    logic [2:0]        w_pop;
    logic [2:0]        w_cnt_nxt;
    logic              w_free;
    logic              w_is32;
    logic              w_outstanding;

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_fetch_addr;
    assign out_valid     = r_out_valid;
    assign out_inst      = r_out_inst;
    assign out_pc        = r_out_pc;
    assign out_is_c      = r_out_is_c;

    assign w_push_en = (r_state == S_WAIT) && mem_resp_valid;
    assign w_ph0     = r_skip_low ? mem_resp_data[31:16] : mem_resp_data[15:0];
    assign w_ph1     = mem_resp_data[31:16];

    // Emission sees the queue with this cycle's response already appended,
    // so a fetched word can be on the output the cycle after it arrives.
    always_comb begin
        w_push_n = 3'd0;
        if (w_push_en) begin
            w_push_n = r_skip_low ? 3'd1 : 3'd2;
        end
        for (int i = 0; i < 8; i++) begin
            w_cq[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < r_count) begin
                w_cq[i] = r_hq[i];
            end
        end
        if (w_push_n != 3'd0) begin
            w_cq[r_count] = w_ph0;
        end
        if (w_push_n == 3'd2) begin
            w_cq[r_count + 3'd1] = w_ph1;
        end
    end

    assign w_cnt  = r_count + w_push_n;
    assign w_free = !r_out_valid || !stall;
    assign w_is32 = (w_cq[0][1:0] == 2'b11);

    always_comb begin
        w_pop = 3'd0;
        if (w_free) begin
            if (w_cnt >= 3'd1 && !w_is32) begin
                w_pop = 3'd1;
            end else if (w_is32 && w_cnt >= 3'd2) begin
                w_pop = 3'd2;
            end
        end
        w_cnt_nxt = w_cnt - w_pop;
        for (int i = 0; i < 4; i++) begin
            w_nq[i] = w_cq[3'(i) + w_pop];
        end
    end

    // A request stays in flight across a redirect when it was already
    // waiting, is just being accepted, or is already being dropped.
    assign w_outstanding =
        ((r_state == S_WAIT || r_state == S_DROP) && !mem_resp_valid) ||
        (r_state == S_REQ && mem_req_ready);

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = w_outstanding ? S_DROP : S_REQ;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cnt_nxt <= 3'd2) w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    if (mem_req_ready) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        w_state_nxt = (w_cnt_nxt <= 3'd2) ? S_REQ : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (mem_resp_valid) w_state_nxt = S_REQ;
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_count      <= 3'd0;
            r_head_pc    <= RESET_PC;
            r_fetch_addr <= RESET_PC & WD_MASK;
            r_skip_low   <= RESET_PC[1];
            r_out_valid  <= 1'b0;
            r_out_inst   <= '0;
            r_out_pc     <= '0;
            r_out_is_c   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_hq[i] <= '0;
            end
        end else if (rdy) begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_count      <= 3'd0;
                r_out_valid  <= 1'b0;
                r_head_pc    <= redirect_pc & HW_MASK;
                r_fetch_addr <= redirect_pc & WD_MASK;
                r_skip_low   <= redirect_pc[1];
            end else begin
                r_count <= w_cnt_nxt;
                for (int i = 0; i < 4; i++) begin
                    r_hq[i] <= w_nq[i];
                end
                if (w_push_en) begin
                    r_fetch_addr <= r_fetch_addr + ADDR_W'(4);
                    r_skip_low   <= 1'b0;
                end
                if (w_free) begin
                    if (w_pop == 3'd1) begin
                        r_out_valid <= 1'b1;
                        r_out_inst  <= {16'h0, w_cq[0]};
                        r_out_pc    <= r_head_pc;
                        r_out_is_c  <= 1'b1;
                        r_head_pc   <= r_head_pc + ADDR_W'(2);
                    end else if (w_pop == 3'd2) begin
                        r_out_valid <= 1'b1;
                        r_out_inst  <= {w_cq[1], w_cq[0]};
                        r_out_pc    <= r_head_pc;
                        r_out_is_c  <= 1'b0;
                        r_head_pc   <= r_head_pc + ADDR_W'(4);
                    end else begin
                        r_out_valid <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: random memory/stall/redirect traffic checked
// against an instruction-stream model derived from a memory image.
module tb_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_is_c;

    always #5 clk = ~clk;

    fetch_aligner #(
        .ADDR_W  (32),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_is_c      (out_is_c)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        is_c;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] gen_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          total = 0;
    int          bad = 0;
    int          mode = 0;
    int          cyc = 0;
    int          nout = 0;
    int          first_cyc = -1;
    bit          go = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0:   return 32'h00A00093;
            32'h4:   return 32'h45050001;
            32'h8:   return 32'h00934581;
            32'hC:   return 32'h000100A0;
            default: begin
                h = (a ^ 32'h5BD1E995) * 32'h9E3779B1;
                h = h ^ (h >> 15);
                h = h * 32'h85EBCA6B;
                h = h ^ (h >> 13);
                return h;
            end
        endcase
    endfunction

    function automatic logic [15:0] hw(input logic [31:0] pc);
        logic [31:0] w;
        w = mem_word({pc[31:2], 2'b00});
        return pc[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic gen_one();
        logic [15:0] h0;
        logic [15:0] h1;
        h0 = hw(gen_pc);
        if (h0[1:0] == 2'b11) begin
            h1 = hw(gen_pc + 32'd2);
            expq.push_back('{inst: {h1, h0}, pc: gen_pc, is_c: 1'b0});
            gen_pc = gen_pc + 32'd4;
        end else begin
            expq.push_back('{inst: {16'h0, h0}, pc: gen_pc, is_c: 1'b1});
            gen_pc = gen_pc + 32'd2;
        end
    endtask

    task automatic chk(input string nm, input logic [65:0] act,
                       input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    // Memory side and stimulus driver
    initial begin
        logic        p_rv;
        logic        p_rr;
        logic        p_rdy;
        logic [31:0] p_addr;
        logic [31:0] npc;
        p_rv = 0; p_rr = 0; p_rdy = 0; p_addr = 0;
        wait (go);
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (p_rdy && p_rv && p_rr) begin
                pend_addr.push_back(p_addr);
                pend_due.push_back(cyc + ((mode == 2) ? $urandom_range(0, 2) : 0));
            end
            rdy   = (mode == 2) ? ($urandom_range(0, 9) != 0) : 1'b1;
            stall = (mode == 1) ? 1'b1 :
                    (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
            if (rdy && pend_addr.size() > 0 && cyc >= pend_due[0]) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            mem_req_ready  = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
            redirect_valid = 1'b0;
            if (mode == 2 && rdy && $urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0:       npc = $urandom;
                    1:       npc = 32'hFFFFFFF0 + $urandom_range(0, 15);
                    2:       npc = 32'h102;
                    default: npc = $urandom & 32'h0000FFFF;
                endcase
                redirect_valid = 1'b1;
                redirect_pc    = npc;
                expq.delete();
                gen_pc = npc & ~32'd1;
            end
            while (expq.size() < 32) gen_one();
            p_rv   = mem_req_valid;
            p_rr   = mem_req_ready;
            p_addr = mem_req_addr;
            p_rdy  = rdy;
        end
    end

    // Output monitor / scoreboard
    initial begin
        logic        redir_prev;
        logic        hold_prev;
        logic [65:0] prev;
        exp_t        e;
        redir_prev = 0; hold_prev = 0; prev = '0;
        wait (go);
        forever begin
            @(negedge clk);
            if (redir_prev) begin
                chk("redirect_clears_valid", 66'(out_valid), 66'(0));
            end else if (hold_prev) begin
                chk("hold_stable", {out_valid, out_inst, out_pc, out_is_c}, prev);
            end
            if (mem_req_valid) begin
                chk("req_align", 66'(mem_req_addr[1:0]), 66'(0));
            end
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (out_valid && rdy && !stall && !redirect_valid) begin
                if (expq.size() == 0) begin
                    chk("stream_underflow", 66'(1), 66'(0));
                end else begin
                    e = expq.pop_front();
                    chk("stream", 66'({out_inst, out_pc, out_is_c}),
                        66'({e.inst, e.pc, e.is_c}));
                    nout++;
                end
            end
            redir_prev = redirect_valid && rdy;
            hold_prev  = out_valid && (stall || !rdy) && !redirect_valid;
            prev       = {out_valid, out_inst, out_pc, out_is_c};
        end
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 66'(out_valid), 66'(0));
        chk("rst_out_inst", 66'(out_inst), 66'(0));
        chk("rst_out_pc", 66'(out_pc), 66'(0));
        chk("rst_out_is_c", 66'(out_is_c), 66'(0));
        chk("rst_req_valid", 66'(mem_req_valid), 66'(1));
        chk("rst_req_addr", 66'(mem_req_addr), 66'(0));
        gen_pc = 32'h0;
        while (expq.size() < 32) gen_one();
        @(posedge clk);
        #1;
        rst = 1'b1;
        go  = 1'b1;
        repeat (30) @(negedge clk);
        chk("first_out_latency", 66'(first_cyc), 66'(3));
        mode = 1;
        repeat (12) @(negedge clk);
        chk("stall_full_noreq", 66'(mem_req_valid), 66'(0));
        chk("stall_holds_valid", 66'(out_valid), 66'(1));
        mode = 2;
        repeat (4000) @(negedge clk);
        mode = 0;
        repeat (40) @(negedge clk);
        chk("enough_outputs", 66'(nout > 1000), 66'(1));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
